// File: rtl/imem_prog_if.sv
// Fetch/program bus of the writable instruction memory. The master side drives
// the fetch and program requests. The slave side is the memory.
interface imem_prog_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              busy;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WIDTH-1:0]  prog_data;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [WIDTH-1:0]  fetch_data;
  logic              fetch_err;

  modport master (
    output prog_we, prog_addr, prog_data, fetch_req, fetch_addr,
    input  busy, fetch_valid, fetch_data, fetch_err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, fetch_req, fetch_addr,
    output busy, fetch_valid, fetch_data, fetch_err
  );
endinterface

// File: rtl/imem_prog.sv
// Writable LEGv8 instruction memory: a one-cycle registered fetch port, a program-load port,
// and a clear sequencer that zeroes every word after reset before any access is accepted.
module imem_prog #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic        clk,
  input  logic        reset,
  imem_prog_if.slave  bus
);

  // Index of the last implemented word. It is one bit wider than an address, so that
  // DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_clr_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              r_fetch_valid;
  logic              r_fetch_err;
  logic [WIDTH-1:0]  r_fetch_data;

  logic              w_clr_last;
  logic              w_prog_ok;
  logic              w_fetch_ok;
  logic              w_bypass;
  logic [WIDTH-1:0]  w_rd_data;

  assign w_clr_last = (r_clr_ptr == LAST_IDX);
  assign w_prog_ok  = (r_state == S_READY) && bus.prog_we &&
                      ({1'b0, bus.prog_addr} <= LAST_IDX);
  assign w_fetch_ok = ({1'b0, bus.fetch_addr} <= LAST_IDX);
  // A write and a fetch to the same word in one cycle return the new word.
  assign w_bypass   = w_prog_ok && (bus.prog_addr == bus.fetch_addr);
  assign w_rd_data  = w_bypass ? bus.prog_data : r_mem[bus.fetch_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == S_CLEAR) && w_clr_last) begin
      w_state_nxt = S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_ptr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset term. The clear sequencer zeroes it over
  // DEPTH cycles, so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_ptr[ADDR_W-1:0]] <= '0;
      end else if (w_prog_ok) begin
        r_mem[bus.prog_addr] <= bus.prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_fetch_data  <= '0;
    end else if ((r_state == S_READY) && bus.fetch_req) begin
      r_fetch_valid <= 1'b1;
      r_fetch_err   <= !w_fetch_ok;
      r_fetch_data  <= w_fetch_ok ? w_rd_data : '0;
    end else begin
      // The data register keeps its last value when there is no request.
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end
  end

  assign bus.busy        = (r_state == S_CLEAR);
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_err   = r_fetch_err;
  assign bus.fetch_data  = r_fetch_data;

endmodule

// File: tb/tb_imem_prog.sv
// Scoreboard bench for imem_prog. A 64-word instance and a 50-word instance share
// the clock and the reset. Expected fetch responses are queued and popped by a monitor.
module tb_imem_prog;

  localparam int W  = 32;
  localparam int AW = 6;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_prog_if #(.WIDTH(W), .ADDR_W(AW)) a_if ();
  imem_prog_if #(.WIDTH(W), .ADDR_W(AW)) b_if ();

  imem_prog #(.WIDTH(W), .ADDR_W(AW), .DEPTH(64)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  imem_prog #(.WIDTH(W), .ADDR_W(AW), .DEPTH(50)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample just after each rising edge and compare against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (a_if.fetch_valid) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 1, 0);
      end else begin
        e = qa.pop_front();
        check("a_data", a_if.fetch_data, e.data);
        check("a_err", a_if.fetch_err, e.err);
        check("a_latency", cyc, e.due);
      end
    end
    if (b_if.fetch_valid) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 1, 0);
      end else begin
        e = qb.pop_front();
        check("b_data", b_if.fetch_data, e.data);
        check("b_err", b_if.fetch_err, e.err);
        check("b_latency", cyc, e.due);
      end
    end
  end

  task automatic idle();
    a_if.fetch_req = 1'b0; a_if.prog_we = 1'b0;
    b_if.fetch_req = 1'b0; b_if.prog_we = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic a_fetch(input logic [AW-1:0] addr, input logic [W-1:0] ed, input logic ee);
    a_if.fetch_req  = 1'b1;
    a_if.fetch_addr = addr;
    qa.push_back(exp_t'{ed, ee, cyc + 1});
  endtask

  task automatic b_fetch(input logic [AW-1:0] addr, input logic [W-1:0] ed, input logic ee);
    b_if.fetch_req  = 1'b1;
    b_if.fetch_addr = addr;
    qb.push_back(exp_t'{ed, ee, cyc + 1});
  endtask

  task automatic a_prog(input logic [AW-1:0] addr, input logic [W-1:0] data);
    a_if.prog_we = 1'b1; a_if.prog_addr = addr; a_if.prog_data = data;
  endtask

  task automatic b_prog(input logic [AW-1:0] addr, input logic [W-1:0] data);
    b_if.prog_we = 1'b1; b_if.prog_addr = addr; b_if.prog_data = data;
  endtask

  // Counts busy cycles of both instances. It is called on the negedge of reset release.
  // Any fetch_req already driven on A stays asserted while counting.
  task automatic count_busy(output int ca, output int cb);
    int n = 0;
    ca = 0;
    cb = 0;
    while ((a_if.busy || b_if.busy) && n < 200) begin
      if (a_if.busy) ca++;
      if (b_if.busy) cb++;
      n++;
      @(negedge clk);
    end
    check("busy_timeout", n < 200, 1);
  endtask

  initial begin
    int ca, cb;
    reset = 1'b1;
    a_if.fetch_addr = '0; a_if.prog_addr = '0; a_if.prog_data = '0;
    b_if.fetch_addr = '0; b_if.prog_addr = '0; b_if.prog_data = '0;
    idle();

    // Reset state, then the initial clear.
    @(negedge clk);
    check("rst_busy", a_if.busy, 1);
    check("rst_valid", a_if.fetch_valid, 0);
    check("rst_err", a_if.fetch_err, 0);
    check("rst_data", a_if.fetch_data, 0);
    reset = 1'b0;
    count_busy(ca, cb);
    check("a_busy_cycles", ca, 64);
    check("b_busy_cycles", cb, 50);

    // Every word reads back as zero after the clear.
    for (int i = 0; i < 64; i++) begin
      a_fetch(AW'(i), '0, 1'b0);
      if (i < 50) b_fetch(AW'(i), '0, 1'b0);
      step();
    end

    // Load three words, then fetch them back to back.
    a_prog(6'd0, 32'hf8000001);  step();
    a_prog(6'd1, 32'hf8008002);  step();
    a_prog(6'd63, 32'hb400001f); step();
    a_fetch(6'd0, 32'hf8000001, 1'b0);  step();
    a_fetch(6'd1, 32'hf8008002, 1'b0);  step();
    a_fetch(6'd63, 32'hb400001f, 1'b0); step();

    // A write beyond DEPTH=50 is dropped, and a fetch beyond it flags an error.
    b_prog(6'd50, 32'hdeadbeef); a_fetch(6'd50, '0, 1'b0); step();
    b_fetch(6'd50, '0, 1'b1); step();
    b_fetch(6'd49, '0, 1'b0); step();
    step();
    check("b_err_clears", b_if.fetch_err, 0);
    check("b_data_holds", b_if.fetch_data, 0);

    // A same-cycle write and fetch returns the new word. Data holds when idle.
    a_prog(6'd5, 32'h8b050083); a_fetch(6'd5, 32'h8b050083, 1'b0); step();
    a_fetch(6'd5, 32'h8b050083, 1'b0); step();
    step();
    check("a_idle_valid", a_if.fetch_valid, 0);
    check("a_data_holds", a_if.fetch_data, 32'h8b050083);

    // Reset in the middle of a fetch stream, with fetch_req held during the clear.
    a_fetch(6'd0, 32'hf8000001, 1'b0); step();
    a_fetch(6'd1, 32'hf8008002, 1'b0); step();
    a_fetch(6'd5, 32'h8b050083, 1'b0); step();
    reset = 1'b1;
    a_if.fetch_req = 1'b1; a_if.fetch_addr = 6'd0;
    @(negedge clk);
    check("rst_stream_valid", a_if.fetch_valid, 0);
    reset = 1'b0;
    count_busy(ca, cb);
    idle();
    check("a_busy_after_stream", ca, 64);
    a_fetch(6'd0, '0, 1'b0); step();
    a_fetch(6'd5, '0, 1'b0); step();

    // Reset again while the clear pointer is at 20.
    reset = 1'b1; @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_clear_busy", a_if.busy, 1);
    reset = 1'b1; @(negedge clk);
    check("mid_clear_rst_busy", a_if.busy, 1);
    reset = 1'b0;
    count_busy(ca, cb);
    check("a_busy_mid_clear", ca, 64);
    check("b_busy_mid_clear", cb, 50);
    a_fetch(6'd63, '0, 1'b0); b_fetch(6'd63, '0, 1'b1); step();

    repeat (3) step();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
